// File: rtl/cacheline_burst_adapter_if.sv
// Line-side (cache) and burst-side (memory) signal bundle for the cacheline burst adapter.
// The adapter uses the slave view; the surrounding environment drives through the master view.
interface cacheline_burst_adapter_if #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
);
  logic [s_line-1:0]  line_i;
  logic [s_line-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [s_burst-1:0] burst_i;
  logic [s_burst-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_burst_adapter.sv
// Converts one cacheline read/write into a num_beats burst on the memory side and
// reassembles read beats into a full line, answering the cache with a one-cycle resp_o.
module cacheline_burst_adapter #(
  parameter int s_offset  = 5,
  parameter int s_line    = 256,
  parameter int s_burst   = 64,
  parameter int num_beats = s_line / s_burst,
  parameter int cnt_w     = $clog2(num_beats)
) (
  input logic                      clk,
  input logic                      rst,
  cacheline_burst_adapter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [cnt_w-1:0] CNT_LAST = cnt_w'(num_beats - 1);
  localparam logic [cnt_w-1:0] CNT_ONE  = cnt_w'(1);

  state_t                            state_q, state_d;
  logic [cnt_w-1:0]                  cnt_q, cnt_d;
  logic [num_beats-1:0][s_burst-1:0] buf_q, buf_d;
  logic [31:0]                       addr_q, addr_d;
  logic [s_line-1:0]                 line_q, line_d;
  logic                              last_beat_s;

  assign last_beat_s = bus.resp_i && (cnt_q == CNT_LAST);

  // State and datapath registers; async reset drops any in-flight burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {cnt_w{1'b0}};
      buf_q   <= {s_line{1'b0}};
      addr_q  <= 32'h0000_0000;
      line_q  <= {s_line{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
    end
  end

  // Next-state logic; write beats read when both requests arrive together
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.write_i) begin
          state_d = WR_BURST;
        end else if (bus.read_i) begin
          state_d = RD_BURST;
        end else begin
          state_d = IDLE;
        end
      end
      RD_BURST: begin
        if (last_beat_s) begin
          state_d = DONE;
        end else begin
          state_d = RD_BURST;
        end
      end
      WR_BURST: begin
        if (last_beat_s) begin
          state_d = DONE;
        end else begin
          state_d = WR_BURST;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: request capture, beat counter, read-beat assembly
  always_comb begin
    cnt_d  = cnt_q;
    buf_d  = buf_q;
    addr_d = addr_q;
    line_d = line_q;
    case (state_q)
      IDLE: begin
        if (bus.write_i) begin
          buf_d  = bus.line_i;
          addr_d = {bus.address_i[31:s_offset], {s_offset{1'b0}}};
          cnt_d  = {cnt_w{1'b0}};
        end else if (bus.read_i) begin
          addr_d = {bus.address_i[31:s_offset], {s_offset{1'b0}}};
          cnt_d  = {cnt_w{1'b0}};
        end else begin
          cnt_d = cnt_q;
        end
      end
      RD_BURST: begin
        if (bus.resp_i) begin
          buf_d[cnt_q] = bus.burst_i;
          cnt_d        = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            line_d = buf_d;
          end else begin
            line_d = line_q;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      WR_BURST: begin
        if (bus.resp_i) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      DONE:    cnt_d = cnt_q;
      default: cnt_d = cnt_q;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    bus.read_o    = 1'b0;
    bus.write_o   = 1'b0;
    bus.resp_o    = 1'b0;
    bus.burst_o   = {s_burst{1'b0}};
    bus.address_o = addr_q;
    bus.line_o    = line_q;
    case (state_q)
      IDLE:     bus.read_o = 1'b0;
      RD_BURST: bus.read_o = 1'b1;
      WR_BURST: begin
        bus.write_o = 1'b1;
        bus.burst_o = buf_q[cnt_q];
      end
      DONE:     bus.resp_o = 1'b1;
      default:  bus.resp_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Directed table-driven bench for cacheline_burst_adapter plus a hand-written async-reset sequence.
module tb_cacheline_burst_adapter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cacheline_burst_adapter_if #(.s_line(256), .s_burst(64)) bus ();

  cacheline_burst_adapter #(
    .s_offset(5), .s_line(256), .s_burst(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic         rd;
    logic         wr;
    logic         rsp;
    logic [31:0]  addr;
    logic [63:0]  beat;
    logic [255:0] line;
    logic         e_rd;
    logic         e_wr;
    logic         e_resp;
    logic [63:0]  e_burst;
    logic [31:0]  e_addr;
  } vec_t;

  vec_t vec_q[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] D2 = 64'hA5A5_5A5A_0F0F_F0F0;
  localparam logic [63:0] D3 = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] E0 = 64'h0E0E_0E0E_0E0E_0E00;
  localparam logic [63:0] E1 = 64'h0E0E_0E0E_0E0E_0E01;
  localparam logic [63:0] E2 = 64'h0E0E_0E0E_0E0E_0E02;
  localparam logic [63:0] E3 = 64'h0E0E_0E0E_0E0E_0E03;
  localparam logic [255:0] LD = {D3, D2, D1, D0};
  localparam logic [255:0] LX = {64'h9999_9999_9999_9999, 64'h8888_8888_8888_8888,
                                 64'h7777_7777_7777_7777, 64'h6666_6666_6666_6666};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rd, input logic wr, input logic rsp, input logic [31:0] addr,
                     input logic [63:0] beat, input logic [255:0] line,
                     input logic e_rd, input logic e_wr, input logic e_resp,
                     input logic [63:0] e_burst, input logic [31:0] e_addr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.rsp = rsp; v.addr = addr; v.beat = beat; v.line = line;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_resp = e_resp; v.e_burst = e_burst; v.e_addr = e_addr;
    vec_q.push_back(v);
  endtask

  task automatic apply_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.read_i    = vec_q[i].rd;
      bus.write_i   = vec_q[i].wr;
      bus.resp_i    = vec_q[i].rsp;
      bus.address_i = vec_q[i].addr;
      bus.burst_i   = vec_q[i].beat;
      bus.line_i    = vec_q[i].line;
      tick();
      chk($sformatf("v%0d read_o", i),    {255'd0, bus.read_o},   {255'd0, vec_q[i].e_rd});
      chk($sformatf("v%0d write_o", i),   {255'd0, bus.write_o},  {255'd0, vec_q[i].e_wr});
      chk($sformatf("v%0d resp_o", i),    {255'd0, bus.resp_o},   {255'd0, vec_q[i].e_resp});
      chk($sformatf("v%0d burst_o", i),   {192'd0, bus.burst_o},  {192'd0, vec_q[i].e_burst});
      chk($sformatf("v%0d address_o", i), {224'd0, bus.address_o}, {224'd0, vec_q[i].e_addr});
    end
  endtask

  initial begin
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.resp_i    = 1'b0;
    bus.address_i = 32'h0000_0000;
    bus.burst_i   = 64'h0;
    bus.line_i    = 256'h0;

    // Read, no wait states (rows 0-5)
    add(1'b1, 1'b0, 1'b0, 32'h0000_1234, 64'h0, LD, 1'b1, 1'b0, 1'b0, 64'h0, 32'h0000_1220);
    add(1'b0, 1'b0, 1'b1, 32'h0000_1234, B1,    LD, 1'b1, 1'b0, 1'b0, 64'h0, 32'h0000_1220);
    add(1'b0, 1'b0, 1'b1, 32'h0000_1234, B2,    LD, 1'b1, 1'b0, 1'b0, 64'h0, 32'h0000_1220);
    add(1'b0, 1'b0, 1'b1, 32'h0000_1234, B3,    LD, 1'b1, 1'b0, 1'b0, 64'h0, 32'h0000_1220);
    add(1'b0, 1'b0, 1'b1, 32'h0000_1234, B4,    LD, 1'b0, 1'b0, 1'b1, 64'h0, 32'h0000_1220);
    add(1'b0, 1'b0, 1'b0, 32'h0000_1234, 64'h0, LD, 1'b0, 1'b0, 0,    64'h0, 32'h0000_1220);
    // Write with waits 1,0,1,0,0,1,1 and mid-burst input toggles; request during DONE; stray resp_i (rows 6-15)
    add(1'b0, 1'b1, 1'b0, 32'h0000_ABCD, 64'h0, LD, 1'b0, 1'b1, 1'b0, D0,    32'h0000_ABC0);
    add(1'b0, 1'b0, 1'b1, 32'h0000_ABCD, 64'h0, LD, 1'b0, 1'b1, 1'b0, D1,    32'h0000_ABC0);
    add(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 64'h0, LX, 1'b0, 1'b1, 1'b0, D1,    32'h0000_ABC0);
    add(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 64'h0, LX, 1'b0, 1'b1, 1'b0, D2,    32'h0000_ABC0);
    add(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 64'h0, LX, 1'b0, 1'b1, 1'b0, D2,    32'h0000_ABC0);
    add(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 64'h0, LX, 1'b0, 1'b1, 1'b0, D2,    32'h0000_ABC0);
    add(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 64'h0, LX, 1'b0, 1'b1, 1'b0, D3,    32'h0000_ABC0);
    add(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 64'h0, LX, 1'b0, 1'b0, 1'b1, 64'h0, 32'h0000_ABC0);
    add(1'b1, 1'b0, 1'b0, 32'h0000_0500, 64'h0, LX, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0000_ABC0);
    add(1'b0, 1'b0, 1'b1, 32'h0000_0500, B4,    LX, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0000_ABC0);
    // Simultaneous read+write: write first, then the held read (rows 16-28)
    add(1'b1, 1'b1, 1'b0, 32'h0000_0100, 64'h0, LD, 1'b0, 1'b1, 1'b0, D0,    32'h0000_0100);
    add(1'b1, 1'b0, 1'b1, 32'h0000_0100, 64'h0, LX, 1'b0, 1'b1, 1'b0, D1,    32'h0000_0100);
    add(1'b1, 1'b0, 1'b1, 32'h0000_0100, 64'h0, LX, 1'b0, 1'b1, 1'b0, D2,    32'h0000_0100);
    add(1'b1, 1'b0, 1'b1, 32'h0000_0100, 64'h0, LX, 1'b0, 1'b1, 1'b0, D3,    32'h0000_0100);
    add(1'b1, 1'b0, 1'b1, 32'h0000_0100, 64'h0, LX, 1'b0, 1'b0, 1'b1, 64'h0, 32'h0000_0100);
    add(1'b1, 1'b0, 1'b0, 32'h0000_0100, 64'h0, LX, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0000_0100);
    add(1'b1, 1'b0, 1'b0, 32'h0000_0100, 64'h0, LX, 1'b1, 1'b0, 1'b0, 64'h0, 32'h0000_0100);
    add(1'b0, 1'b0, 1'b1, 32'h0000_0100, E0,    LX, 1'b1, 1'b0, 1'b0, 64'h0, 32'h0000_0100);
    add(1'b0, 1'b0, 1'b1, 32'h0000_0100, E1,    LX, 1'b1, 1'b0, 1'b0, 64'h0, 32'h0000_0100);
    add(1'b0, 1'b0, 1'b0, 32'h0000_0100, B3,    LX, 1'b1, 1'b0, 1'b0, 64'h0, 32'h0000_0100);
    add(1'b0, 1'b0, 1'b1, 32'h0000_0100, E2,    LX, 1'b1, 1'b0, 1'b0, 64'h0, 32'h0000_0100);
    add(1'b0, 1'b0, 1'b1, 32'h0000_0100, E3,    LX, 1'b0, 1'b0, 1'b1, 64'h0, 32'h0000_0100);
    add(1'b0, 1'b0, 1'b0, 32'h0000_0100, 64'h0, LX, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0000_0100);

    #3;
    chk("reset read_o",    {255'd0, bus.read_o},    256'd0);
    chk("reset write_o",   {255'd0, bus.write_o},   256'd0);
    chk("reset resp_o",    {255'd0, bus.resp_o},    256'd0);
    chk("reset burst_o",   {192'd0, bus.burst_o},   256'd0);
    chk("reset address_o", {224'd0, bus.address_o}, 256'd0);
    chk("reset line_o",    bus.line_o,              256'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    apply_range(0, 5);
    chk("read line_o", bus.line_o, {B4, B3, B2, B1});
    apply_range(6, 15);
    chk("write keeps line_o", bus.line_o, {B4, B3, B2, B1});
    apply_range(16, 28);
    chk("deferred read line_o", bus.line_o, {E3, E2, E1, E0});

    // Async reset while the third beat is pending
    bus.address_i = 32'h0000_2010;
    bus.read_i    = 1'b1;
    tick();
    bus.read_i  = 1'b0;
    bus.resp_i  = 1'b1;
    bus.burst_i = 64'hAAAA_AAAA_AAAA_AAAA;
    tick();
    bus.burst_i = 64'hBBBB_BBBB_BBBB_BBBB;
    tick();
    chk("pre-reset read_o", {255'd0, bus.read_o}, 256'd1);
    bus.resp_i = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("async rst read_o",    {255'd0, bus.read_o},    256'd0);
    chk("async rst resp_o",    {255'd0, bus.resp_o},    256'd0);
    chk("async rst line_o",    bus.line_o,              256'd0);
    chk("async rst address_o", {224'd0, bus.address_o}, 256'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.address_i = 32'h0000_301F;
    bus.read_i    = 1'b1;
    tick();
    chk("post-reset address_o", {224'd0, bus.address_o}, {224'd0, 32'h0000_3000});
    bus.read_i = 1'b0;
    bus.resp_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      bus.burst_i = 64'hC0C0_0000_0000_0000 | 64'(b);
      tick();
    end
    bus.resp_i = 1'b0;
    chk("post-reset resp_o", {255'd0, bus.resp_o}, 256'd1);
    chk("post-reset line_o", bus.line_o,
        {64'hC0C0_0000_0000_0003, 64'hC0C0_0000_0000_0002,
         64'hC0C0_0000_0000_0001, 64'hC0C0_0000_0000_0000});
    tick();
    chk("post-reset idle resp_o", {255'd0, bus.resp_o}, 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cacheline_burst_adapter.md
Name: cacheline_burst_adapter

Overview:
Sits directly downstream of the cache, between its 256-bit physical-memory port and the 64-bit burst physical memory. Converts one cacheline read or write into a 4-beat burst, and reassembles read beats into a full line. Presents a single-request / single-response handshake to the cache. The cache's pmem_* signals connect directly to the line-side ports.

Parameters:
s_offset, 5, byte-offset bits of a cacheline; address_o low s_offset bits forced to 0
s_line, 256, cacheline width in bits
s_burst, 64, burst beat width in bits
num_beats, s_line/s_burst (4), beats per line; counter width clog2(num_beats)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
line_i  in  s_line  writeback line from cache (pmem_wdata)
line_o  out  s_line  assembled read line to cache (pmem_rdata)
address_i  in  32  line address from cache (pmem_address)
read_i  in  1  line read request (pmem_read)
write_i  in  1  line write request (pmem_write)
resp_o  out  1  one-cycle completion pulse to cache (pmem_resp)
burst_i  in  s_burst  read beat from memory
burst_o  out  s_burst  write beat to memory
address_o  out  32  burst start address to memory
read_o  out  1  burst read request
write_o  out  1  burst write request
resp_i  in  1  memory beat-valid / beat-accepted strobe

Behaviour:
- Decided: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: line_o=0, burst_o=0, address_o=0, read_o=0, write_o=0, resp_o=0, beat counter=0, state=IDLE, internal line buffer=0.
- FSM states: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - Outputs read_o, write_o, and resp_o are 0.
  - If write_i=1: latch line_i into the buffer, latch address_i into the address register, clear the counter, go to WR_BURST.
  - Otherwise, if read_i=1: latch address_i, clear the counter, go to RD_BURST.
  - If write_i and read_i are both 1, the write wins. Read is ignored that cycle and is taken once the cache re-requests.
  - resp_i in IDLE is ignored.
- Address rule: address_o = {latched address[31:s_offset], s_offset zeros}. It is registered and stable for the entire burst.
- RD_BURST:
  - read_o=1 continuously.
  - On each cycle with resp_i=1: buffer[cnt*s_burst +: s_burst] <= burst_i; cnt <= cnt+1.
  - Beat 0 is the lowest 64 bits.
  - When resp_i=1 and cnt==num_beats-1: copy the completed line to line_o and go to DONE.
  - Cycles with resp_i=0 are wait states: no change.
- WR_BURST:
  - write_o=1 continuously; burst_o = buffer[cnt*s_burst +: s_burst] combinationally from cnt.
  - On resp_i=1: cnt <= cnt+1.
  - On resp_i=1 with cnt==num_beats-1: go to DONE.
- DONE:
  - resp_o=1 for exactly one cycle; read_o=write_o=0; unconditional return to IDLE.
  - Because the request is not re-sampled until IDLE, a request still asserted during DONE does not start a second burst in the same cycle.
- Latency:
  - Best case, a line op completes with resp_o num_beats+1 cycles after the request is sampled in IDLE (4 beat cycles + DONE).
  - Each memory wait cycle adds one cycle.
- line_o holds the last completed read line until the next read completes. Writes never modify line_o.
- Changes on line_i, address_i, read_i, or write_i during a burst are ignored (all values latched at start).
- Counter wraps to 0 naturally after the last beat and is also cleared on entry to a burst.
- Reset asserted mid-burst:
  - Immediately (asynchronously) drops read_o/write_o, clears cnt, returns to IDLE.
  - A partial line is never presented, and no resp_o is produced for the aborted op.
- resp_i held high continuously gives back-to-back beats with no bubble.

Test Plan:
- Read, no waits: read_i=1, address_i=0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles -> address_o=0x0000_1220, read_o high 4 cycles, then resp_o one cycle, line_o={0x44..44,0x33..33,0x22..22,0x11..11}.
- Write with waits: write_i=1, line_i={D3,D2,D1,D0}, resp_i pattern 1,0,1,0,0,1,1 -> burst_o shows D0,D1,D1,D2,D2,D2,D3 and advances only after each resp_i; write_o high 7 cycles; resp_o pulses once; line_o unchanged.
- Simultaneous read_i=1 and write_i=1 in IDLE -> WR_BURST taken first, read_o stays 0; read burst begins only after DONE→IDLE with read_i still high.
- Async reset during beat 2 of a read -> read_o=0 and resp_o=0 in the same cycle; cnt=0; a subsequent read returns a correct full line with no stale beats.
- Stray resp_i=1 in IDLE, and request inputs toggled mid-burst -> no state change in IDLE; the in-flight burst uses the originally latched address and line.
